csr_trap_unit: RTL and testbench

- Parametrised successor of the RV32I machine-mode CSR/exception unit.
- Adds mstatus (MIE/MPIE), mie/mip, vectored or direct mtvec, mret, three interrupt sources, mtval capture, mcountinhibit and NUM_HPM event counters of configurable width.
- Sits beside the XB (writeback) stage. Takes CSR accesses and exception reports from the pipeline; returns registered read data, trap redirects and mepc.

---
 rtl/csr_pkg.sv | 54 +++++
 rtl/csr_trap_unit_if.sv | 35 +++
 rtl/csr_counter.sv | 54 +++++
 rtl/csr_trap_unit.sv | 257 +++++++++++++++++++++++++
 tb/tb_csr_trap_unit.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR and trap unit:
// CSR addresses, cause codes, operation encoding and FSM states.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MCNTINH   = 12'h320;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MHPMCNT3  = 12'hB03;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MARCHID   = 12'hF12;
  localparam logic [11:0] CSR_MIMPID    = 12'hF13;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  localparam logic [3:0] CAUSE_IMISALIGN = 4'd0;
  localparam logic [3:0] CAUSE_ILLEGAL   = 4'd2;
  localparam logic [3:0] CAUSE_LMISALIGN = 4'd4;
  localparam logic [3:0] CAUSE_SMISALIGN = 4'd6;
  localparam logic [3:0] IRQ_MSI         = 4'd3;
  localparam logic [3:0] IRQ_MTI         = 4'd7;
  localparam logic [3:0] IRQ_MEI         = 4'd11;

  localparam logic [31:0] IRQ_MASK = 32'h0000_0888;

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_RW   = 2'b01,
    OP_RS   = 2'b10,
    OP_RC   = 2'b11
  } csr_op_e;

  typedef enum logic [1:0] {
    S_RUN,
    S_TRAP,
    S_RET
  } trap_state_e;

  // Counter slot k -> CSR number low bits (mcycle, minstret, hpm3..)
  function automatic logic [4:0] cnt_num(input int k);
    if (k == 0) return 5'd0;
    if (k == 1) return 5'd2;
    return 5'(k + 1);
  endfunction

endpackage

// File: rtl/csr_trap_unit_if.sv
// Pipeline-facing bundle of the CSR/trap unit: CSR access,
// exception report, mret and the redirect outputs.
interface csr_trap_unit_if;
  logic        retire;
  logic        csr_valid;
  logic [1:0]  csr_op;
  logic        csr_imm;
  logic        csr_rd_nz;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [4:0]  csr_uimm;
  logic [31:0] csr_rdata;
  logic        exc_valid;
  logic [3:0]  exc_cause;
  logic [31:0] exc_pc;
  logic [31:0] exc_tval;
  logic        mret;
  logic        trap_take;
  logic [31:0] trap_target;
  logic [31:0] csr_mepc;

  modport master (
    output retire, csr_valid, csr_op, csr_imm,
    output csr_rd_nz, csr_addr, csr_wdata, csr_uimm,
    output exc_valid, exc_cause, exc_pc, exc_tval, mret,
    input  csr_rdata, trap_take, trap_target, csr_mepc
  );

  modport slave (
    input  retire, csr_valid, csr_op, csr_imm,
    input  csr_rd_nz, csr_addr, csr_wdata, csr_uimm,
    input  exc_valid, exc_cause, exc_pc, exc_tval, mret,
    output csr_rdata, trap_take, trap_target, csr_mepc
  );
endinterface

// File: rtl/csr_counter.sv
// W-bit event counter with inhibit and 32-bit lo/hi CSR halves.
// A half write replaces that half and wins over the increment.
module csr_counter #(
  parameter int W = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc,
  input  logic        inhibit,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [31:0] rd_lo,
  output logic [31:0] rd_hi
);

  localparam bit HAS_HI = (W > 32);

  logic [W-1:0] cnt;
  logic [W-1:0] wval;
  logic         wr_any;

  assign wr_any = wr_lo || (HAS_HI && wr_hi);
  assign rd_lo  = cnt[31:0];

  if (HAS_HI) begin : g_hi
    // Merge a half write into the current count
    always_comb begin
      wval = cnt;
      if (wr_lo) wval[31:0] = wdata;
      if (wr_hi) wval[W-1:32] = wdata[W-33:0];
    end
    assign rd_hi = 32'(cnt[W-1:32]);
  end else begin : g_nohi
    // Only the low half exists
    always_comb begin
      wval = cnt;
      if (wr_lo) wval = wdata[W-1:0];
    end
    assign rd_hi = '0;
  end

  // Count register: write, else gated increment
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (wr_any) begin
      cnt <= wval;
    end else if (inc && !inhibit) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file, trap/mret sequencer and counters,
// sitting beside the writeback stage.
module csr_trap_unit
  import csr_pkg::*;
#(
  parameter int          NUM_HPM   = 4,
  parameter int          CNT_W     = 64,
  parameter logic [31:0] MTVEC_RST = 32'h0000_0000,
  parameter bit          VECT_EN   = 1'b1,
  parameter logic [31:0] HART_ID   = 32'h0,
  localparam int         HW = (NUM_HPM > 0) ? NUM_HPM : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          irq_sw,
  input  logic          irq_timer,
  input  logic          irq_ext,
  input  logic [HW-1:0] hpm_event,
  csr_trap_unit_if.slave bus
);

  localparam int NC = 2 + NUM_HPM;
  localparam logic [63:0] HPM_BITS =
    ((64'd1 << NUM_HPM) - 64'd1) << 3;
  localparam logic [31:0] INH_MASK =
    HPM_BITS[31:0] | 32'h5;

  trap_state_e state;
  logic        mst_mie, mst_mpie;
  logic [31:0] mie_r, mtvec, mscratch;
  logic [31:0] mepc, mcause, mtval, minh;
  logic [2:0]  mip_q;
  logic [31:0] mip_v;
  logic [31:0] rdata_q, tgt_q;
  logic        take_q;

  logic [31:0] c_lo [NC];
  logic [31:0] c_hi [NC];

  csr_op_e     op;
  logic [11:0] a;
  logic [4:0]  n;
  logic        sel_clo, sel_chi, sel_evt;
  logic [31:0] cnt_rd, rv, nv, opnd;
  logic        impl, ro, do_wr, run;
  logic        illegal, pend, trap_now, mret_now, wr;
  logic [31:0] irq_act;
  logic        t_int;
  logic [3:0]  t_cause;
  logic [31:0] t_tval, base, tgt;
  logic        unused_ok;

  assign op  = csr_op_e'(bus.csr_op);
  assign a   = bus.csr_addr;
  assign n   = a[4:0];
  assign run = (state == S_RUN);

  assign sel_clo = (a[11:5] == 7'h58);
  assign sel_chi = (a[11:5] == 7'h5C);
  assign sel_evt = (a[11:5] == 7'h19) && (n >= 5'd3);

  assign mip_v = {20'b0, mip_q[2], 3'b0,
                  mip_q[1], 3'b0, mip_q[0], 3'b0};

  assign unused_ok = &{1'b0, bus.csr_rd_nz, hpm_event};

  // Select the addressed counter half
  always_comb begin
    cnt_rd = '0;
    for (int k = 0; k < NC; k++) begin
      if (n == cnt_num(k)) begin
        cnt_rd = sel_chi ? c_hi[k] : c_lo[k];
      end
    end
  end

  // Address decode and read mux
  always_comb begin
    rv   = '0;
    impl = 1'b1;
    unique case (1'b1)
      sel_clo, sel_chi: begin
        impl = (n != 5'd1);
        rv   = cnt_rd;
      end
      sel_evt:               rv = '0;
      a == CSR_MVENDORID,
      a == CSR_MARCHID,
      a == CSR_MIMPID:       rv = '0;
      a == CSR_MHARTID:      rv = HART_ID;
      a == CSR_MSTATUS:
        rv = {24'b0, mst_mpie, 3'b0, mst_mie, 3'b0};
      a == CSR_MIE:          rv = mie_r;
      a == CSR_MIP:          rv = mip_v;
      a == CSR_MTVEC:        rv = mtvec;
      a == CSR_MCNTINH:      rv = minh;
      a == CSR_MSCRATCH:     rv = mscratch;
      a == CSR_MEPC:         rv = mepc;
      a == CSR_MCAUSE:       rv = mcause;
      a == CSR_MTVAL:        rv = mtval;
      default:               impl = 1'b0;
    endcase
  end

  assign opnd = bus.csr_imm ? {27'b0, bus.csr_uimm}
                            : bus.csr_wdata;

  // Read-modify-write value
  always_comb begin
    nv = rv;
    unique case (op)
      OP_RW:   nv = opnd;
      OP_RS:   nv = rv | opnd;
      OP_RC:   nv = rv & ~opnd;
      default: nv = rv;
    endcase
  end

  assign do_wr = (op == OP_RW) ||
                 ((op == OP_RS || op == OP_RC) &&
                  (opnd != 32'b0));
  assign ro = (a[11:10] == 2'b11);

  assign illegal = run && bus.csr_valid &&
                   (!impl || (ro && do_wr));
  assign irq_act = mie_r & mip_v;
  assign pend    = mst_mie && (irq_act != 32'b0);
  assign trap_now = illegal || (run && bus.exc_valid) ||
                    (run && !bus.mret && pend);
  assign mret_now = run && bus.mret && !illegal &&
                    !bus.exc_valid;
  assign wr = run && bus.csr_valid && do_wr &&
              !trap_now && !mret_now;

  // Trap cause selection by priority
  always_comb begin
    t_int   = 1'b0;
    t_cause = CAUSE_ILLEGAL;
    t_tval  = '0;
    if (illegal) begin
      t_cause = CAUSE_ILLEGAL;
    end else if (bus.exc_valid) begin
      t_cause = bus.exc_cause;
      t_tval  = bus.exc_tval;
    end else begin
      t_int = 1'b1;
      if (irq_act[11])     t_cause = IRQ_MEI;
      else if (irq_act[3]) t_cause = IRQ_MSI;
      else                 t_cause = IRQ_MTI;
    end
  end

  assign base = {mtvec[31:2], 2'b00};
  assign tgt  = (t_int && mtvec[0])
              ? base + {26'b0, t_cause, 2'b00}
              : base;

  // Trap FSM, redirect outputs and trap-record CSRs
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_RUN;
      take_q   <= 1'b0;
      tgt_q    <= '0;
      mst_mie  <= 1'b0;
      mst_mpie <= 1'b0;
      mepc     <= '0;
      mcause   <= '0;
      mtval    <= '0;
    end else begin
      unique case (state)
        S_RUN: begin
          if (trap_now) begin
            state    <= S_TRAP;
            take_q   <= 1'b1;
            tgt_q    <= tgt;
            mepc     <= {bus.exc_pc[31:2], 2'b00};
            mcause   <= {t_int, 27'b0, t_cause};
            mtval    <= t_tval;
            mst_mpie <= mst_mie;
            mst_mie  <= 1'b0;
          end else if (mret_now) begin
            state    <= S_RET;
            take_q   <= 1'b1;
            tgt_q    <= mepc;
            mst_mie  <= mst_mpie;
            mst_mpie <= 1'b1;
          end else begin
            take_q <= 1'b0;
            if (wr && a == CSR_MSTATUS) begin
              mst_mie  <= nv[3];
              mst_mpie <= nv[7];
            end
            if (wr && a == CSR_MEPC) begin
              mepc <= {nv[31:2], 2'b00};
            end
            if (wr && a == CSR_MCAUSE) mcause <= nv;
            if (wr && a == CSR_MTVAL)  mtval  <= nv;
          end
        end
        default: begin
          take_q <= 1'b0;
          state  <= S_RUN;
        end
      endcase
    end
  end

  // Plain CSRs, interrupt sampling and read data
  always_ff @(posedge clk) begin
    if (reset) begin
      mie_r    <= '0;
      mtvec    <= MTVEC_RST;
      mscratch <= '0;
      minh     <= '0;
      mip_q    <= '0;
      rdata_q  <= '0;
    end else begin
      mip_q <= {irq_ext, irq_timer, irq_sw};
      if (run && bus.csr_valid) rdata_q <= rv;
      if (wr && a == CSR_MIE) mie_r <= nv & IRQ_MASK;
      if (wr && a == CSR_MTVEC) begin
        mtvec <= {nv[31:2], 1'b0, nv[0] & VECT_EN};
      end
      if (wr && a == CSR_MSCRATCH) mscratch <= nv;
      if (wr && a == CSR_MCNTINH) minh <= nv & INH_MASK;
    end
  end

  for (genvar k = 0; k < NC; k++) begin : g_cnt
    localparam logic [4:0] CN = cnt_num(k);
    logic inc;
    if (k == 0) begin : g_cyc
      assign inc = 1'b1;
    end else if (k == 1) begin : g_ret
      assign inc = bus.retire && run && !trap_now;
    end else begin : g_hpm
      assign inc = run && hpm_event[k-2];
    end
    csr_counter #(.W(CNT_W)) u_cnt (
      .clk     (clk),
      .reset   (reset),
      .inc     (inc),
      .inhibit (minh[CN]),
      .wr_lo   (wr && sel_clo && n == CN),
      .wr_hi   (wr && sel_chi && n == CN),
      .wdata   (nv),
      .rd_lo   (c_lo[k]),
      .rd_hi   (c_hi[k])
    );
  end

  assign bus.csr_rdata   = rdata_q;
  assign bus.trap_take   = take_q;
  assign bus.trap_target = tgt_q;
  assign bus.csr_mepc    = mepc;

endmodule

// File: tb/tb_csr_trap_unit.sv
// Scoreboard bench for csr_trap_unit: stimulus queues expected
// read data and redirects, a negedge monitor compares them.
module tb_csr_trap_unit;

  typedef struct {
    bit          chk;
    logic [31:0] val;
    logic [11:0] a;
  } rexp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       irq_sw = 1'b0;
  logic       irq_timer = 1'b0;
  logic       irq_ext = 1'b0;
  logic [3:0] hpm_event = 4'b0;

  int checks = 0;
  int errs   = 0;
  rexp_t       rq[$];
  logic [31:0] tq[$];
  bit          rd_pend = 1'b0;

  csr_trap_unit_if bus();

  csr_trap_unit #(
    .NUM_HPM   (4),
    .CNT_W     (40),
    .MTVEC_RST (32'h80),
    .VECT_EN   (1'b1),
    .HART_ID   (32'h5)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .irq_sw    (irq_sw),
    .irq_timer (irq_timer),
    .irq_ext   (irq_ext),
    .hpm_event (hpm_event),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Monitor: read data one cycle after an access, redirect pulses
  always @(negedge clk) begin
    rexp_t e;
    if (rd_pend) begin
      if (rq.size() == 0) begin
        check("rd_queue_empty", 32'd1, 32'd0);
      end else begin
        e = rq.pop_front();
        if (e.chk) check($sformatf("rd_%h", e.a),
                         bus.csr_rdata, e.val);
      end
    end
    rd_pend = bus.csr_valid && !reset;
    if (bus.trap_take) begin
      if (tq.size() == 0) begin
        check("unexpected_trap", bus.trap_target, 32'hx);
      end else begin
        check("trap_target", bus.trap_target, tq.pop_front());
      end
    end
  end

  task automatic csr(input logic [1:0]  op,
                     input logic [11:0] a,
                     input logic [31:0] d,
                     input logic [31:0] exp,
                     input bit chk = 1'b1,
                     input bit trap = 1'b0,
                     input bit imm = 1'b0,
                     input logic [4:0] uimm = 5'd0);
    rexp_t e;
    e.chk = chk;
    e.val = exp;
    e.a   = a;
    rq.push_back(e);
    bus.csr_valid = 1'b1;
    bus.csr_op    = op;
    bus.csr_addr  = a;
    bus.csr_wdata = d;
    bus.csr_imm   = imm;
    bus.csr_uimm  = uimm;
    @(posedge clk); #1;
    bus.csr_valid = 1'b0;
    bus.csr_op    = 2'b00;
    bus.csr_imm   = 1'b0;
    if (trap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic rd(input logic [11:0] a,
                    input logic [31:0] exp);
    csr(2'b10, a, 32'h0, exp);
  endtask

  task automatic do_exc(input logic [3:0]  c,
                        input logic [31:0] pc,
                        input logic [31:0] tv,
                        input logic [31:0] tgt);
    tq.push_back(tgt);
    bus.exc_valid = 1'b1;
    bus.exc_cause = c;
    bus.exc_pc    = pc;
    bus.exc_tval  = tv;
    @(posedge clk); #1;
    bus.exc_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_mret(input logic [31:0] tgt);
    tq.push_back(tgt);
    bus.mret = 1'b1;
    @(posedge clk); #1;
    bus.mret = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    bus.retire    = 1'b0;
    bus.csr_valid = 1'b0;
    bus.csr_op    = 2'b00;
    bus.csr_imm   = 1'b0;
    bus.csr_rd_nz = 1'b1;
    bus.csr_addr  = 12'h0;
    bus.csr_wdata = 32'h0;
    bus.csr_uimm  = 5'h0;
    bus.exc_valid = 1'b0;
    bus.exc_cause = 4'h0;
    bus.exc_pc    = 32'h0;
    bus.exc_tval  = 32'h0;
    bus.mret      = 1'b0;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_rdata", bus.csr_rdata, 32'h0);
    check("rst_take", {31'b0, bus.trap_take}, 32'h0);
    check("rst_mepc", bus.csr_mepc, 32'h0);

    repeat (3) @(posedge clk);
    #1;
    rd(12'hB00, 32'd3);
    rd(12'hF14, 32'h5);

    csr(2'b01, 12'h340, 32'hDEADBEEF, 32'h0);
    csr(2'b11, 12'h340, 32'h0000FFFF, 32'hDEADBEEF);
    rd(12'h340, 32'hDEAD0000);
    csr(2'b10, 12'h340, 32'h0, 32'hDEAD0000,
        1'b1, 1'b0, 1'b1, 5'h3);
    rd(12'h340, 32'hDEAD0003);

    csr(2'b01, 12'h341, 32'h107, 32'h0);
    rd(12'h341, 32'h104);

    csr(2'b01, 12'h300, 32'h8, 32'h0);
    do_exc(4'd4, 32'h100, 32'h203, 32'h80);
    rd(12'h342, 32'h4);
    rd(12'h341, 32'h100);
    rd(12'h343, 32'h203);
    rd(12'h300, 32'h80);
    check("mepc_port", bus.csr_mepc, 32'h100);
    do_mret(32'h100);
    rd(12'h300, 32'h88);

    csr(2'b01, 12'h305, 32'h201, 32'h80);
    csr(2'b01, 12'h304, 32'h80, 32'h0);
    bus.exc_pc = 32'h300;
    tq.push_back(32'h21C);
    irq_timer = 1'b1;
    repeat (4) @(posedge clk);
    #1 irq_timer = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rd(12'h342, 32'h80000007);
    rd(12'h341, 32'h300);
    rd(12'h343, 32'h0);
    rd(12'h300, 32'h80);
    do_mret(32'h300);
    csr(2'b01, 12'h304, 32'h880, 32'h80);
    tq.push_back(32'h22C);
    irq_timer = 1'b1;
    irq_ext   = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    irq_timer = 1'b0;
    irq_ext   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rd(12'h342, 32'h8000000B);

    csr(2'b01, 12'hB00, 32'hFFFFFFFF, 32'h0, 1'b0);
    csr(2'b01, 12'hB80, 32'h1FF, 32'h0);
    rd(12'hB80, 32'hFF);
    rd(12'hB80, 32'h0);
    rd(12'hB00, 32'h1);

    bus.exc_pc = 32'h400;
    tq.push_back(32'h200);
    csr(2'b01, 12'h7C0, 32'h1234, 32'h0, 1'b0, 1'b1);
    rd(12'h342, 32'h2);
    rd(12'h343, 32'h0);
    rd(12'h341, 32'h400);
    rd(12'h340, 32'hDEAD0003);
    tq.push_back(32'h200);
    csr(2'b01, 12'hF14, 32'h9, 32'h0, 1'b0, 1'b1);
    rd(12'hF14, 32'h5);
    rd(12'hF11, 32'h0);

    csr(2'b01, 12'hB0A, 32'h55, 32'h0);
    rd(12'hB0A, 32'h0);
    csr(2'b01, 12'h323, 32'h1, 32'h0);
    csr(2'b01, 12'hB03, 32'h0, 32'h0);
    hpm_event = 4'b0001;
    repeat (3) @(posedge clk);
    #1 hpm_event = 4'b0000;
    rd(12'hB03, 32'h3);

    bus.retire = 1'b1;
    repeat (2) @(posedge clk);
    #1 bus.retire = 1'b0;
    rd(12'hB02, 32'h2);
    csr(2'b01, 12'h320, 32'hFFFFFFFF, 32'h0);
    rd(12'h320, 32'h7D);
    bus.retire = 1'b1;
    repeat (2) @(posedge clk);
    #1 bus.retire = 1'b0;
    rd(12'hB02, 32'h2);

    repeat (5) @(posedge clk);
    #1;
    check("rd_leftover", rq.size(), 32'd0);
    check("trap_leftover", tq.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
